// File: rtl/mips_trace_capture.sv
// Trace capture unit for a single-cycle MIPS core: run/halt/timeout FSM plus a
// trace FIFO of {pc, mem_addr, write_data, zero} entries drained through rd_en.
module mips_trace_capture #(
   parameter int WIDTH          = 32,
   parameter int DEPTH          = 16,
   parameter int HALT_REPEAT    = 2,
   parameter int MAX_CYCLES     = 1024,
   parameter int PC_CHANGE_ONLY = 0,
   parameter int OVERWRITE      = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic [WIDTH-1:0]         pc,
   input  logic [WIDTH-1:0]         mem_addr,
   input  logic [WIDTH-1:0]         write_data,
   input  logic                     zero,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_pc,
   output logic [WIDTH-1:0]         rd_mem_addr,
   output logic [WIDTH-1:0]         rd_wdata,
   output logic                     rd_zero,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     halted,
   output logic                     timeout,
   output logic [31:0]              cycle_count,
   output logic [1:0]               state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 3 * WIDTH + 1;
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [8:0]    HALT_LIM  = 9'(HALT_REPEAT);
   localparam logic [31:0]   CYC_LIM   = 32'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_HALTED  = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [31:0]       cycle_count_r;
   logic [7:0]        halt_cnt_r;
   logic [WIDTH-1:0]  prev_pc_r;
   logic              prev_valid_r;
   logic              halted_r;
   logic              timeout_r;

   logic [EW-1:0]     mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic              overflow_r;
   logic              rd_valid_r;
   logic [WIDTH-1:0]  rd_pc_r;
   logic [WIDTH-1:0]  rd_mem_addr_r;
   logic [WIDTH-1:0]  rd_wdata_r;
   logic              rd_zero_r;

   logic              run_s;
   logic              restart_s;
   logic              pc_same_s;
   logic              halt_hit_s;
   logic              limit_hit_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic              wr_en_s;
   logic [EW-1:0]     entry_s;
   logic [EW-1:0]     rd_entry_s;

   assign run_s       = (state_r == S_RUN);
   assign restart_s   = !run_s && start;
   assign pc_same_s   = prev_valid_r && (pc == prev_pc_r);
   assign halt_hit_s  = pc_same_s && (({1'b0, halt_cnt_r} + 9'd1) >= HALT_LIM);
   assign limit_hit_s = (cycle_count_r == CYC_LIM);
   assign full_s      = (count_r == CNT_FULL);
   assign empty_s     = (count_r == {CW{1'b0}});
   assign push_s      = run_s && ((PC_CHANGE_ONLY == 0) || !pc_same_s);
   assign pop_s       = rd_en && !empty_s;
   // A full FIFO still accepts the push when a pop frees a slot or the oldest is overwritten
   assign wr_en_s     = !rst && push_s && (!full_s || pop_s || (OVERWRITE != 0));
   assign entry_s     = {pc, mem_addr, write_data, zero};
   assign rd_entry_s  = mem_r[rd_ptr_r];

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_nxt_s = S_RUN;
            else       state_nxt_s = S_IDLE;
         end
         S_RUN: begin
            if (stop)             state_nxt_s = S_IDLE;
            else if (halt_hit_s)  state_nxt_s = S_HALTED;
            else if (limit_hit_s) state_nxt_s = S_TIMEOUT;
            else                  state_nxt_s = S_RUN;
         end
         S_HALTED, S_TIMEOUT: begin
            if (start) state_nxt_s = S_RUN;
            else       state_nxt_s = state_r;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Run bookkeeping: cycle counter, repeated-pc tracking and sticky termination flags
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count_r <= 32'd0;
         halt_cnt_r    <= 8'd0;
         prev_pc_r     <= {WIDTH{1'b0}};
         prev_valid_r  <= 1'b0;
         halted_r      <= 1'b0;
         timeout_r     <= 1'b0;
      end else if (restart_s) begin
         cycle_count_r <= 32'd0;
         halt_cnt_r    <= 8'd0;
         prev_valid_r  <= 1'b0;
         halted_r      <= 1'b0;
         timeout_r     <= 1'b0;
      end else if (run_s) begin
         prev_pc_r    <= pc;
         prev_valid_r <= 1'b1;
         if (!pc_same_s)                halt_cnt_r <= 8'd0;
         else if (halt_cnt_r != 8'hFF)  halt_cnt_r <= halt_cnt_r + 8'd1;
         // The cycle that leaves RUN is not counted
         if ((state_nxt_s == S_RUN) && (cycle_count_r != 32'hFFFF_FFFF))
            cycle_count_r <= cycle_count_r + 32'd1;
         if (state_nxt_s == S_HALTED)  halted_r  <= 1'b1;
         if (state_nxt_s == S_TIMEOUT) timeout_r <= 1'b1;
      end
   end

   // Trace storage; contents are only observable after being written
   always_ff @(posedge clk) begin
      if (wr_en_s) mem_r[wr_ptr_r] <= entry_s;
   end

   // FIFO pointers, occupancy, overflow flag and registered read port
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r      <= {AW{1'b0}};
         rd_ptr_r      <= {AW{1'b0}};
         count_r       <= {CW{1'b0}};
         overflow_r    <= 1'b0;
         rd_valid_r    <= 1'b0;
         rd_pc_r       <= {WIDTH{1'b0}};
         rd_mem_addr_r <= {WIDTH{1'b0}};
         rd_wdata_r    <= {WIDTH{1'b0}};
         rd_zero_r     <= 1'b0;
      end else begin
         rd_valid_r <= pop_s;
         if (pop_s) begin
            rd_pc_r       <= rd_entry_s[EW-1 -: WIDTH];
            rd_mem_addr_r <= rd_entry_s[2*WIDTH -: WIDTH];
            rd_wdata_r    <= rd_entry_s[WIDTH -: WIDTH];
            rd_zero_r     <= rd_entry_s[0];
         end
         if (push_s && pop_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else if (push_s) begin
            if (!full_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
               count_r  <= count_r + CNT_ONE;
            end else if (OVERWRITE != 0) begin
               wr_ptr_r   <= wr_ptr_r + PTR_ONE;
               rd_ptr_r   <= rd_ptr_r + PTR_ONE;
               overflow_r <= 1'b1;
            end else begin
               overflow_r <= 1'b1;
            end
         end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r  <= count_r - CNT_ONE;
         end
      end
   end

   assign rd_valid    = rd_valid_r;
   assign rd_pc       = rd_pc_r;
   assign rd_mem_addr = rd_mem_addr_r;
   assign rd_wdata    = rd_wdata_r;
   assign rd_zero     = rd_zero_r;
   assign count       = count_r;
   assign full        = full_s;
   assign empty       = empty_s;
   assign overflow    = overflow_r;
   assign halted      = halted_r;
   assign timeout     = timeout_r;
   assign cycle_count = cycle_count_r;
   assign state       = state_r;

endmodule

// File: tb/tb_mips_trace_capture.sv
// Bench for mips_trace_capture: four differently configured instances share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_mips_trace_capture;

   localparam int NI = 4;
   localparam int CFG_D [NI] = '{16, 4, 4, 8};
   localparam int CFG_H [NI] = '{2, 2, 2, 1};
   localparam int CFG_M [NI] = '{1024, 8, 64, 32};
   localparam int CFG_P [NI] = '{0, 0, 1, 1};
   localparam int CFG_O [NI] = '{0, 0, 1, 0};

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        z;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst, start, stop, zero, rd_en;
   logic [31:0] pc, mem_addr, write_data;

   logic        rv_a  [NI];
   logic [31:0] rpc_a [NI];
   logic [31:0] rma_a [NI];
   logic [31:0] rwd_a [NI];
   logic        rz_a  [NI];
   logic [4:0]  cnt_a [NI];
   logic        full_a [NI];
   logic        empty_a [NI];
   logic        ovf_a [NI];
   logic        hlt_a [NI];
   logic        tmo_a [NI];
   logic [31:0] cc_a  [NI];
   logic [1:0]  st_a  [NI];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // model state per instance
   entry_t      mq   [NI][$];
   entry_t      m_rd [NI];
   logic        m_rv [NI];
   logic [1:0]  m_st [NI];
   logic [31:0] m_cc [NI];
   int          m_hc [NI];
   logic        m_pv [NI];
   logic [31:0] m_ppc [NI];
   logic        m_ovf [NI];
   logic        m_hlt [NI];
   logic        m_tmo [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [$clog2(CFG_D[g]):0] cnt_w;
      mips_trace_capture #(
         .WIDTH(32), .DEPTH(CFG_D[g]), .HALT_REPEAT(CFG_H[g]), .MAX_CYCLES(CFG_M[g]),
         .PC_CHANGE_ONLY(CFG_P[g]), .OVERWRITE(CFG_O[g])
      ) u_dut (
         .clk(clk), .rst(rst), .start(start), .stop(stop), .pc(pc),
         .mem_addr(mem_addr), .write_data(write_data), .zero(zero), .rd_en(rd_en),
         .rd_valid(rv_a[g]), .rd_pc(rpc_a[g]), .rd_mem_addr(rma_a[g]), .rd_wdata(rwd_a[g]),
         .rd_zero(rz_a[g]), .count(cnt_w), .full(full_a[g]), .empty(empty_a[g]),
         .overflow(ovf_a[g]), .halted(hlt_a[g]), .timeout(tmo_a[g]),
         .cycle_count(cc_a[g]), .state(st_a[g])
      );
      assign cnt_a[g] = 5'(cnt_w);
   end

   task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, inst, $time, act, exp);
      end
   endtask

   // Reference model: FIFO as a queue, run control from the rules directly
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         bit     same, pop, push;
         int     streak;
         entry_t e, dump;
         if (rst) begin
            mq[i].delete();
            m_rd[i] = '0; m_rv[i] = 1'b0; m_st[i] = 2'd0; m_cc[i] = 32'd0; m_hc[i] = 0;
            m_pv[i] = 1'b0; m_ovf[i] = 1'b0; m_hlt[i] = 1'b0; m_tmo[i] = 1'b0;
            chk_en = 1'b1;
         end else begin
            same = m_pv[i] && (pc == m_ppc[i]);
            pop  = rd_en && (mq[i].size() != 0);
            push = (m_st[i] == 2'd1) && ((CFG_P[i] == 0) || !same);
            m_rv[i] = pop;
            if (pop) m_rd[i] = mq[i].pop_front();
            if (push) begin
               e.pc = pc; e.addr = mem_addr; e.wd = write_data; e.z = zero;
               if (mq[i].size() < CFG_D[i]) begin
                  mq[i].push_back(e);
               end else begin
                  m_ovf[i] = 1'b1;
                  if (CFG_O[i] != 0) begin
                     dump = mq[i].pop_front();
                     mq[i].push_back(e);
                  end
               end
            end
            if (m_st[i] != 2'd1) begin
               if (start) begin
                  m_st[i] = 2'd1; m_cc[i] = 32'd0; m_hc[i] = 0; m_pv[i] = 1'b0;
                  m_hlt[i] = 1'b0; m_tmo[i] = 1'b0;
               end
            end else begin
               streak = same ? m_hc[i] + 1 : 0;
               if (stop) m_st[i] = 2'd0;
               else if (streak >= CFG_H[i]) begin m_st[i] = 2'd2; m_hlt[i] = 1'b1; end
               else if (m_cc[i] == 32'(CFG_M[i] - 1)) begin m_st[i] = 2'd3; m_tmo[i] = 1'b1; end
               if (m_st[i] == 2'd1 && m_cc[i] != 32'hFFFF_FFFF) m_cc[i] = m_cc[i] + 32'd1;
               m_hc[i] = streak; m_ppc[i] = pc; m_pv[i] = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of all instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            chk("state", i, 64'(st_a[i]), 64'(m_st[i]));
            chk("count", i, 64'(cnt_a[i]), 64'(mq[i].size()));
            chk("full", i, 64'(full_a[i]), 64'(mq[i].size() == CFG_D[i]));
            chk("empty", i, 64'(empty_a[i]), 64'(mq[i].size() == 0));
            chk("overflow", i, 64'(ovf_a[i]), 64'(m_ovf[i]));
            chk("halted", i, 64'(hlt_a[i]), 64'(m_hlt[i]));
            chk("timeout", i, 64'(tmo_a[i]), 64'(m_tmo[i]));
            chk("cycle_count", i, 64'(cc_a[i]), 64'(m_cc[i]));
            chk("rd_valid", i, 64'(rv_a[i]), 64'(m_rv[i]));
            chk("rd_pc", i, 64'(rpc_a[i]), 64'(m_rd[i].pc));
            chk("rd_mem_addr", i, 64'(rma_a[i]), 64'(m_rd[i].addr));
            chk("rd_wdata", i, 64'(rwd_a[i]), 64'(m_rd[i].wd));
            chk("rd_zero", i, 64'(rz_a[i]), 64'(m_rd[i].z));
         end
      end
   end

   task automatic step(input logic s, input logic sp, input logic [31:0] p, input logic re);
      start = s; stop = sp; pc = p; rd_en = re;
      mem_addr = $urandom; write_data = $urandom; zero = 1'($urandom_range(0, 1));
      @(negedge clk);
   endtask

   task automatic do_rst();
      rst = 1'b1;
      step(1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rp;
      rst = 1'b1; start = 1'b0; stop = 1'b0; rd_en = 1'b0; zero = 1'b0;
      pc = 32'h0; mem_addr = 32'h0; write_data = 32'h0; rp = 32'h0;

      // basic capture of four pcs, then four pops
      do_rst();
      chk("lit_reset_state", 0, 64'(st_a[0]), 64'd0);
      chk("lit_reset_empty", 0, 64'(empty_a[0]), 64'd1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h4, 1'b0);
      step(1'b0, 1'b0, 32'h8, 1'b0);
      step(1'b0, 1'b1, 32'hC, 1'b0);
      chk("lit_basic_count", 0, 64'(cnt_a[0]), 64'd4);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 32'hC, 1'b1);
         chk("lit_basic_rv", 0, 64'(rv_a[0]), 64'd1);
         chk("lit_basic_rd_pc", 0, 64'(rpc_a[0]), 64'(4 * k));
      end
      chk("lit_basic_empty", 0, 64'(empty_a[0]), 64'd1);

      // halt after repeated pc
      do_rst();
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h4, 1'b0);
      step(1'b0, 1'b0, 32'h8, 1'b0);
      step(1'b0, 1'b0, 32'h8, 1'b0);
      chk("lit_halt_notyet", 2, 64'(st_a[2]), 64'd1);
      step(1'b0, 1'b0, 32'h8, 1'b0);
      chk("lit_halt_state", 2, 64'(st_a[2]), 64'd2);
      chk("lit_halt_flag", 2, 64'(hlt_a[2]), 64'd1);
      chk("lit_halt_count_pco", 2, 64'(cnt_a[2]), 64'd3);
      chk("lit_halt_count_all", 0, 64'(cnt_a[0]), 64'd5);

      // overflow policies on DEPTH=4
      do_rst();
      step(1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 6; k++) step(1'b0, (k == 5), 32'(4 * k), 1'b0);
      chk("lit_ovf_count", 1, 64'(cnt_a[1]), 64'd4);
      chk("lit_ovf_flag", 1, 64'(ovf_a[1]), 64'd1);
      chk("lit_ovw_flag", 2, 64'(ovf_a[2]), 64'd1);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         chk("lit_drop_rd_pc", 1, 64'(rpc_a[1]), 64'(4 * k));
         chk("lit_ovw_rd_pc", 2, 64'(rpc_a[2]), 64'(8 + 4 * k));
      end
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("lit_empty_pop_rv", 1, 64'(rv_a[1]), 64'd0);
      chk("lit_empty_pop_hold", 1, 64'(rpc_a[1]), 64'hC);

      // timeout after exactly MAX_CYCLES run cycles
      do_rst();
      step(1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 32'(32'h100 + 4 * k), 1'b0);
         if (k == 6) chk("lit_tmo_notyet", 1, 64'(st_a[1]), 64'd1);
         if (k == 7) begin
            chk("lit_tmo_state", 1, 64'(st_a[1]), 64'd3);
            chk("lit_tmo_flag", 1, 64'(tmo_a[1]), 64'd1);
            chk("lit_tmo_cycles", 1, 64'(cc_a[1]), 64'd7);
            chk("lit_tmo_count", 1, 64'(cnt_a[1]), 64'd4);
            chk("lit_tmo_ovf", 1, 64'(ovf_a[1]), 64'd1);
         end
      end
      chk("lit_tmo_terminal", 1, 64'(st_a[1]), 64'd3);

      // full FIFO with simultaneous pop and push
      do_rst();
      step(1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'(4 * k), 1'b0);
      chk("lit_full", 1, 64'(full_a[1]), 64'd1);
      step(1'b0, 1'b0, 32'h10, 1'b1);
      chk("lit_pp_count", 1, 64'(cnt_a[1]), 64'd4);
      chk("lit_pp_ovf", 1, 64'(ovf_a[1]), 64'd0);
      chk("lit_pp_rd_pc", 1, 64'(rpc_a[1]), 64'd0);

      // reset in the middle of RUN
      do_rst();
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h4, 1'b0);
      step(1'b0, 1'b0, 32'h8, 1'b0);
      step(1'b0, 1'b0, 32'hC, 1'b1);
      chk("lit_mid_count", 0, 64'(cnt_a[0]), 64'd3);
      rst = 1'b1;
      step(1'b0, 1'b0, 32'h10, 1'b1);
      rst = 1'b0;
      chk("lit_mid_state", 0, 64'(st_a[0]), 64'd0);
      chk("lit_mid_cnt0", 0, 64'(cnt_a[0]), 64'd0);
      chk("lit_mid_rv", 0, 64'(rv_a[0]), 64'd0);
      chk("lit_mid_flags", 0, 64'({ovf_a[0], hlt_a[0], tmo_a[0]}), 64'd0);
      step(1'b0, 1'b0, 32'h10, 1'b1);
      chk("lit_mid_pop_rv", 0, 64'(rv_a[0]), 64'd0);

      // randomized traffic
      do_rst();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 2) != 0) rp = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0), rp,
              ($urandom_range(0, 1) == 1));
      end
      rst = 1'b0;
      step(1'b0, 1'b0, rp, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_trace_capture.md
MIPS_TRACE_CAPTURE -- requirements
Module: mips_trace_capture

Interface
REQ-001 Parameter: WIDTH, 32, width of the PC, memory-address and write-data fields.
REQ-002 Parameter: DEPTH, 16, number of trace entries; a power of two, at least 2.
REQ-003 Parameter: HALT_REPEAT, 2, consecutive unchanged-PC cycles that declare the core halted; range 1..255.
REQ-004 Parameter: MAX_CYCLES, 1024, run-cycle limit that raises timeout; at least 1.
REQ-005 Parameter: PC_CHANGE_ONLY, 0, capture mode: 0 = capture every run cycle, 1 = capture only when pc differs from the previous cycle's pc.
REQ-006 Parameter: OVERWRITE, 0, full policy: 0 = drop the new entry, 1 = overwrite the oldest entry.
REQ-007 Ports, listed as name, direction, width, meaning:
- clk, in, 1: the single clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: pulse; IDLE -> RUN.
- stop, in, 1: pulse; RUN -> IDLE.
- pc, in, WIDTH: core instruction address.
- mem_addr, in, WIDTH: core data-memory address.
- write_data, in, WIDTH: core store data.
- zero, in, 1: core ALU zero flag.
- rd_en, in, 1: pop one trace entry.
- rd_valid, out, 1: registered read data valid.
- rd_pc, rd_mem_addr, rd_wdata, out, WIDTH each: popped entry fields.
- rd_zero, out, 1: popped entry zero flag.
- count, out, log2(DEPTH)+1: entries stored.
- full, empty, out, 1 each: FIFO status.
- overflow, out, 1: sticky; an entry was lost.
- halted, timeout, out, 1 each: sticky termination flags.
- cycle_count, out, 32: number of RUN cycles.
- state, out, 2: current FSM state.

Function
REQ-008 FSM states and encodings: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
REQ-009 IDLE transitions: start=1 -> RUN; on entry, cycle_count, the halt counter and prev_pc valid are cleared; FIFO contents are kept.
REQ-010 RUN transitions, by priority: stop -> IDLE; else halt counter reaching HALT_REPEAT -> HALTED; else cycle_count reaching MAX_CYCLES-1 -> TIMEOUT.
REQ-011 HALTED and TIMEOUT are terminal; they exit only via rst or start, and start -> RUN.
REQ-012 In RUN, cycle_count increments by one per cycle and saturates at 2^32-1.
REQ-013 Halt counter: increments when prev_pc is valid and pc == prev_pc; otherwise it clears; prev_pc is registered every RUN cycle.
REQ-014 halted is set on the RUN->HALTED edge; timeout is set on the RUN->TIMEOUT edge; both are sticky until rst or start.
REQ-015 Capture eligibility: state == RUN and (PC_CHANGE_ONLY == 0, or prev_pc is invalid, or pc != prev_pc).
REQ-016 A captured entry is {pc, mem_addr, write_data, zero} sampled in that cycle.
REQ-017 The cycle that causes the HALTED or TIMEOUT transition is itself captured if it is eligible.
REQ-018 Pop: rd_en=1 and not empty -> the oldest entry is presented on the rd_* outputs and rd_valid=1 in the next cycle; otherwise rd_valid=0 next cycle.
REQ-019 rd_* data holds its last value when rd_valid=0.
REQ-020 rd_en while empty is ignored; count does not underflow.
REQ-021 Push while full with OVERWRITE=0: the entry is dropped, overflow is set, count is unchanged.
REQ-022 Push while full with OVERWRITE=1: the oldest entry is discarded, the new entry is written, overflow is set, count stays at DEPTH.
REQ-023 Simultaneous push and pop when full: the pop is served first, then the push succeeds; overflow is not set; count is unchanged.
REQ-024 Simultaneous push and pop when empty: rd_valid=0 and count becomes 1.
REQ-025 Pointers wrap modulo DEPTH.
REQ-026 full = (count == DEPTH); empty = (count == 0); both are derived from the registered count.
REQ-027 Pops are allowed in every state.

Reset
REQ-028 When rst=1 at a clock edge, the following are set: state=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, halted=0, timeout=0, cycle_count=0, rd_valid=0, rd_pc=0, rd_mem_addr=0, rd_wdata=0, rd_zero=0, prev_pc valid=0.
REQ-029 rst has priority over start, stop, rd_en and capture; a reset in mid-RUN discards all trace entries.
REQ-030 FIFO storage RAM contents are not reset and are never observable before a write.

Verification
REQ-031 Defaults; rst, then start; pc steps 0,4,8,C; then 4 pops -> rd_pc 0,4,8,C on consecutive cycles, each one cycle after its rd_en; empty=1 at the end.
REQ-032 HALT_REPEAT=2; pc sequence 0,4,8,8,8 -> HALTED entered after the third 8 and halted=1; with PC_CHANGE_ONLY=1, exactly 3 entries are stored.
REQ-033 DEPTH=4, OVERWRITE=0; 6 distinct pcs 0..14 (step 4) -> count=4, overflow=1, pops return 0,4,8,C; with OVERWRITE=1, pops return 8,C,10,14.
REQ-034 MAX_CYCLES=8, pc increments every cycle -> timeout=1 and state=3 after exactly 8 RUN cycles; cycle_count=7 (the terminating cycle is not counted); 4 entries with DEPTH=4, overflow=1.
REQ-035 Full FIFO with simultaneous rd_en and push -> count stays at DEPTH, overflow=0, the oldest entry is popped.
REQ-036 rst asserted in RUN with count=3 -> next cycle state=0, count=0, rd_valid=0, all flags 0; a subsequent rd_en yields rd_valid=0.
